// File: rtl/xadc_scan_pwm_if.sv
// DRP and conversion-strobe bundle between the channel scanner and the XADC primitive.
interface xadc_scan_pwm_if;
  logic        eoc;
  logic        den;
  logic        dwe;
  logic [6:0]  daddr;
  logic        drdy;
  logic [15:0] do_in;

  modport master (
    input  eoc,
    input  drdy,
    input  do_in,
    output den,
    output dwe,
    output daddr
  );

  modport slave (
    output eoc,
    output drdy,
    output do_in,
    input  den,
    input  dwe,
    input  daddr
  );
endinterface

// File: rtl/xadc_scan_pwm.sv
// Round-robin XADC DRP reader driving one PWM output per channel at the captured duty.
// Optional per-channel exponential smoothing is enabled by defining XADC_SCAN_EMA_EN.
module xadc_scan_pwm #(
  parameter int unsigned    NUM_CH       = 4,
  parameter int unsigned    PWM_W        = 8,
  parameter logic [111:0]   CH_ADDRS     = {84'd0, 7'h16, 7'h1F, 7'h17, 7'h1E},
  parameter int unsigned    DRDY_TIMEOUT = 255,
  parameter int unsigned    EMA_SHIFT    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  xadc_scan_pwm_if.master         drp,
  output logic [NUM_CH*PWM_W-1:0] duty,
  output logic [NUM_CH-1:0]       pwm,
  output logic                    frame_done,
  output logic                    drp_err
);

  localparam int unsigned      IdxW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(NUM_CH - 1);
  localparam logic [15:0]      TmoLast = 16'(DRDY_TIMEOUT - 1);
  localparam logic [PWM_W-1:0] PwmMax  = '1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                         state_q, state_d;
  logic [IdxW-1:0]                idx_q, idx_d;
  logic [15:0]                    tmo_q, tmo_d;
  logic                           den_q, den_d;
  logic                           frame_q, frame_d;
  logic                           err_q, err_d;
  logic [NUM_CH-1:0][PWM_W-1:0]   sample_q, sample_d;
  logic [NUM_CH-1:0][PWM_W-1:0]   duty_q;
  logic [PWM_W-1:0]               cnt_q;
  logic [NUM_CH-1:0]              pwm_q;
  logic [PWM_W-1:0]               new_smp, upd_smp;
  logic [6:0]                     addr_tbl [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_addr
    assign addr_tbl[i] = CH_ADDRS[7*i +: 7];
  end

  assign new_smp = drp.do_in[15 -: PWM_W];

`ifdef XADC_SCAN_EMA_EN
  logic [NUM_CH-1:0]   primed_q, primed_d;
  logic [PWM_W-1:0]    cur_smp;
  logic signed [PWM_W:0] diff, step, sum;

  assign cur_smp = sample_q[idx_q];
  assign diff    = $signed({1'b0, new_smp}) - $signed({1'b0, cur_smp});
  assign step    = diff >>> EMA_SHIFT;
  // Moves a fraction of the way toward new, so the sum stays inside 0..PwmMax.
  assign sum     = $signed({1'b0, cur_smp}) + step;
  assign upd_smp = primed_q[idx_q] ? sum[PWM_W-1:0] : new_smp;
`else
  assign upd_smp = new_smp;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    den_d    = 1'b0;
    frame_d  = 1'b0;
    err_d    = 1'b0;
    sample_d = sample_q;
`ifdef XADC_SCAN_EMA_EN
    primed_d = primed_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (drp.eoc) begin
          state_d = StIssue;
          den_d   = 1'b1;
        end
      end
      StIssue: begin
        state_d = StWait;
        tmo_d   = '0;
      end
      StWait: begin
        // drdy wins over a timeout expiring in the same cycle.
        if (drp.drdy) begin
          sample_d[idx_q] = upd_smp;
`ifdef XADC_SCAN_EMA_EN
          primed_d[idx_q] = 1'b1;
`endif
          frame_d = (idx_q == IdxLast);
          idx_d   = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
          state_d = StIdle;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      tmo_q    <= '0;
      den_q    <= 1'b0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
      sample_q <= '0;
`ifdef XADC_SCAN_EMA_EN
      primed_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      den_q    <= den_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
      sample_q <= sample_d;
`ifdef XADC_SCAN_EMA_EN
      primed_q <= primed_d;
`endif
    end
  end

  // Duties load only at the last count so each period uses one consistent value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= '0;
    end else begin
      cnt_q <= cnt_q + PWM_W'(1);
      if (cnt_q == PwmMax) begin
        duty_q <= sample_q;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_q[i] <= (cnt_q < duty_q[i]) || (duty_q[i] == PwmMax);
      end
    end
  end

  assign drp.den    = den_q;
  assign drp.dwe    = 1'b0;
  assign drp.daddr  = addr_tbl[idx_q];
  assign duty       = duty_q;
  assign pwm        = pwm_q;
  assign frame_done = frame_q;
  assign drp_err    = err_q;

endmodule
